// File: rtl/spi_axi_lite_mst.sv
// AXI4-Lite controlled SPI master with configurable word width, chip selects and FIFO depth.
// Runtime CPOL/CPHA/bit-order/divider; the engine latches settings per word.
module spi_axi_lite_mst #(
  parameter int unsigned DW         = 8,
  parameter int unsigned NCS        = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           S_AXI_ACLK,
  input  logic           S_AXI_ARESETN,
  input  logic [3:0]     S_AXI_AWADDR,
  input  logic           S_AXI_AWVALID,
  output logic           S_AXI_AWREADY,
  input  logic [31:0]    S_AXI_WDATA,
  input  logic [3:0]     S_AXI_WSTRB,
  input  logic           S_AXI_WVALID,
  output logic           S_AXI_WREADY,
  output logic [1:0]     S_AXI_BRESP,
  output logic           S_AXI_BVALID,
  input  logic           S_AXI_BREADY,
  input  logic [3:0]     S_AXI_ARADDR,
  input  logic           S_AXI_ARVALID,
  output logic           S_AXI_ARREADY,
  output logic [31:0]    S_AXI_RDATA,
  output logic [1:0]     S_AXI_RRESP,
  output logic           S_AXI_RVALID,
  input  logic           S_AXI_RREADY,
  output logic           SCLK,
  output logic           MOSI,
  input  logic           MISO,
  output logic [NCS-1:0] CS_N
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned HW = $clog2(2 * DW);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t state, state_nxt;

  logic       en, cpol, cpha, lsb_first;
  logic [2:0] cs_sel;
  logic [7:0] div;
  logic       rx_ovf;

  logic [DW-1:0] tx_mem [FIFO_DEPTH];
  logic [DW-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_push_req, rx_pop, ovf_set;
  logic [DW-1:0] tx_head;

  logic          wr_hs, rd_hs;
  logic [31:0]   rd_word;

  logic [7:0]    cnt, l_div;
  logic [HW-1:0] half;
  logic          l_cpha, l_lsb;
  logic [DW-1:0] tx_sr, rx_sr;
  logic          tick, last_half, sample;

  logic          unused_bits;
  assign unused_bits = ^{S_AXI_WSTRB, S_AXI_WDATA, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_hs = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = S_AXI_ARREADY && S_AXI_ARVALID;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = ((tx_wr - tx_rd) == PW'(FIFO_DEPTH));
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = ((rx_wr - rx_rd) == PW'(FIFO_DEPTH));
  assign tx_head  = tx_mem[tx_rd[AW-1:0]];

  // A push into a full FIFO still lands when the opposite side pops in the same cycle.
  assign tx_pop      = (state == IDLE) && en && !tx_empty;
  assign tx_push     = wr_hs && (S_AXI_AWADDR[3:2] == 2'd2) && (!tx_full || tx_pop);
  assign rx_pop      = rd_hs && (S_AXI_ARADDR[3:2] == 2'd3) && !rx_empty;
  assign rx_push_req = (state == HOLD) && tick;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign ovf_set     = rx_push_req && !rx_push;

  assign tick      = (cnt == l_div);
  assign last_half = (half == HW'(2 * DW - 1));
  assign sample    = (half[0] == l_cpha);

  // Read data mux.
  always_comb begin
    rd_word = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rd_word = {8'h00, div, 5'h00, cs_sel, 4'h0, lsb_first, cpha, cpol, en};
      2'd1: rd_word = {28'h0, rx_ovf, rx_empty, tx_full, (state != IDLE)};
      2'd3: if (!rx_empty) rd_word = 32'(rx_mem[rx_rd[AW-1:0]]);
      default: ;
    endcase
  end

  // AXI-Lite slave channels and CTRL register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= 2'b00;
      S_AXI_RDATA   <= '0;
      en            <= 1'b0;
      cpol          <= 1'b0;
      cpha          <= 1'b0;
      lsb_first     <= 1'b0;
      cs_sel        <= '0;
      div           <= '0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      if (wr_hs) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= ((S_AXI_AWADDR[3:2] == 2'd2) && tx_full && !tx_pop) ? 2'b10 : 2'b00;
        if (S_AXI_AWADDR[3:2] == 2'd0) begin
          en        <= S_AXI_WDATA[0];
          cpol      <= S_AXI_WDATA[1];
          cpha      <= S_AXI_WDATA[2];
          lsb_first <= S_AXI_WDATA[3];
          cs_sel    <= S_AXI_WDATA[10:8];
          div       <= S_AXI_WDATA[23:16];
        end
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
      if (rd_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= ((S_AXI_ARADDR[3:2] == 2'd3) && rx_empty) ? 2'b10 : 2'b00;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Sticky overflow flag; a new overflow wins over a same-cycle clear.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rx_ovf <= 1'b0;
    end else if (ovf_set) begin
      rx_ovf <= 1'b1;
    end else if (wr_hs && (S_AXI_AWADDR[3:2] == 2'd1) && S_AXI_WDATA[3]) begin
      rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= S_AXI_WDATA[DW-1:0];
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_sr;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_pop) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && last_half) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift engine datapath: half-period timing, pin drive and shift registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cnt    <= '0;
      half   <= '0;
      l_div  <= '0;
      l_cpha <= 1'b0;
      l_lsb  <= 1'b0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      SCLK   <= 1'b0;
      MOSI   <= 1'b0;
      CS_N   <= '1;
    end else begin
      cnt <= (state == IDLE || tick) ? 8'd0 : cnt + 8'd1;
      case (state)
        IDLE: begin
          half <= '0;
          SCLK <= cpol;
          if (tx_pop) begin
            l_div  <= div;
            l_cpha <= cpha;
            l_lsb  <= lsb_first;
            CS_N   <= ~(NCS'(1) << cs_sel);
            // With CPHA=0 the first bit must already be on MOSI before the first edge.
            if (!cpha) begin
              MOSI  <= lsb_first ? tx_head[0] : tx_head[DW-1];
              tx_sr <= lsb_first ? (tx_head >> 1) : (tx_head << 1);
            end else begin
              MOSI  <= 1'b0;
              tx_sr <= tx_head;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            SCLK <= ~SCLK;
            half <= half + HW'(1);
            if (sample) begin
              rx_sr <= l_lsb ? {MISO, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], MISO};
            end else if (!last_half) begin
              MOSI  <= l_lsb ? tx_sr[0] : tx_sr[DW-1];
              tx_sr <= l_lsb ? (tx_sr >> 1) : (tx_sr << 1);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            CS_N <= '1;
            MOSI <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
